pipe_stage_chain: RTL
=====================

# pipe_stage_chain

Parametrised pipeline-register chain replacing the per-stage hand-wired latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined datapath with one generic block. It carries a WIDTH-bit payload plus a valid bit through STAGES registers and handles per-stage hold (stall), per-stage flush (bubble/kill) and bubble insertion between a held stage and a free older stage. It also keeps saturating stall, bubble and flush counters for performance debug. The datapath instantiates one chain and packs its control and data fields into the payload.

## Interface
- STAGES, 4: number of register slots; slot 0 is youngest (IF/ID), slot STAGES-1 is oldest (MEM/WB); legal range 2..8.
- WIDTH, 128: payload bits per slot.
- CNT_W, 16: width of each performance counter.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- in_valid  in  1  new payload offered to slot 0.
- in_data  in  WIDTH  payload for slot 0.
- in_ready  out  1  slot 0 accepts this cycle; equals ~freeze[0].
- hold  in  STAGES  hold[s]=1: slot s must keep its contents this cycle.
- flush  in  STAGES  flush[s]=1: slot s becomes a bubble at the next edge.
- stage_valid  out  STAGES  valid bit of each slot.
- stage_data  out  STAGES*WIDTH  slot s at bits [s*WIDTH +: WIDTH].
- out_fire  out  1  oldest slot retires this cycle.
- cnt_clr  in  1  synchronous clear of all counters.
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- freeze[STAGES-1] = hold[STAGES-1]; freeze[s] = hold[s] | freeze[s+1]. An older frozen slot freezes all younger slots.
- Next state per slot s, in priority order:
  - flush[s]: valid <= 0, data <= PIPE_BUBBLE. Flush overrides hold and freeze.
  - freeze[s]: slot unchanged.
  - s==0: valid <= in_valid, data <= in_data.
  - freeze[s-1]: bubble inserted; valid <= 0, data <= PIPE_BUBBLE.
  - otherwise: slot s loads slot s-1 (valid and data).
- No bubble collapsing. An invalid slot still freezes when held.
- out_fire = stage_valid[STAGES-1] & ~freeze[STAGES-1] & ~flush[STAGES-1].
- Counters increment by 1 per cycle and saturate at all-ones:
  - stall_cnt: in_valid & freeze[0].
  - bubble_cnt: any slot s>0 takes the bubble-insertion branch with flush[s]=0. Counts once per cycle, not per slot.
  - flush_cnt: any flush bit is set and the flushed slot was valid.
- cnt_clr clears all counters to 0 and wins over increment in the same cycle.
- Outputs are registered values, except in_ready and out_fire, which are combinational from the registered state and inputs.

## Timing
- Reset (nRST low, asynchronous): all stage_valid = 0, all stage_data = PIPE_BUBBLE, all counters = 0. in_ready = 1 while hold = 0.
- Reset asserted mid-operation discards every slot immediately; no retire occurs in that cycle.
- Latency: a payload accepted at edge k reaches slot STAGES-1 at edge k+STAGES-1 if no freeze occurs. out_fire asserts in the cycle after that edge.
- Throughput: one payload per cycle.
- Handshake: a payload is taken only when in_valid & in_ready at the rising edge. If in_ready=0 the source must hold in_data stable.
- Simultaneous hold[s] and flush[s]: slot s becomes a bubble. Younger slots remain frozen by hold[s]. Slot s+1 receives a bubble if it is not frozen.
- flush on slot 0 with in_valid=1: the input is dropped. in_ready still reflects freeze[0], so the source must treat the beat as consumed.

## Structure
- Shared package pipe_pkg:
  - PIPE_BUBBLE constant: all zero, which decodes as nop with WEN/dWEN/dREN clear.
  - Typedef pipe_slot_t: struct holding the valid bit and the payload.
  - The per-stage field structs that the datapath packs into the payload.
- One sub-module, pipe_slot. It is a single register slot with inputs for freeze, flush, bubble-select, previous slot and reset.
- The chain generates STAGES instances of pipe_slot plus the freeze chain and the counters.

## Test plan
- Reset, then feed payloads 0x1..0x6 back-to-back with hold=0 and flush=0 (STAGES=4, WIDTH=32):
  - slot 3 shows 0x1 after 4 edges.
  - out_fire is high for 6 consecutive cycles.
  - all counters stay 0.
- Load-use stall: pulse hold[1] for 1 cycle with slots full (0x4, 0x3, 0x2, 0x1 in slots 0..3):
  - slots 0 and 1 keep 0x4 and 0x3; slot 2 becomes a bubble (valid 0); slot 3 gets 0x2.
  - in_ready = 0 during the pulse.
  - stall_cnt = 1 and bubble_cnt = 1.
- Branch flush: assert flush[1:0]=2'b11 with hold=0:
  - slots 0 and 1 become invalid with data 0.
  - flush_cnt increments by 1.
- Hold and flush together: assert hold[2] and flush[2] on a valid slot 2:
  - slot 2 becomes a bubble; slots 0 and 1 stay frozen; slot 3 becomes a bubble.
  - out_fire follows the old slot 3 contents.
- Saturation and clear (CNT_W=4):
  - hold[3] asserted for 20 cycles with in_valid=1 gives stall_cnt = 0xF.
  - cnt_clr together with a further stall cycle gives stall_cnt = 0.
- Async reset mid-stream: drop nRST between clock edges while slots hold 0x5..0x8:
  - all valid bits clear immediately and out_fire falls the same cycle.
  - after release, the chain accepts new input on the first edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and slot/field types for the pipeline register chain
package pipe_pkg;

    localparam int PIPE_WIDTH = 128;

    // A bubble is all zero so every packed control field decodes as nop with WEN/dWEN/dREN clear.
    localparam logic                  PIPE_BUBBLE_BIT = 1'b0;
    localparam logic [PIPE_WIDTH-1:0] PIPE_BUBBLE     = '0;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_WIDTH-1:0] payload;
    } pipe_slot_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        wen;
        logic        dwen;
        logic        dren;
        logic [4:0]  rd;
        logic [31:0] opa;
        logic [31:0] opb;
    } id_ex_t;

    typedef struct packed {
        logic        wen;
        logic        dwen;
        logic        dren;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } mem_wb_t;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - handshake and slot-observation bundle of the pipeline register chain
interface pipe_stage_chain_if #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 128
);
    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_ready;
    logic [STAGES-1:0]         hold;
    logic [STAGES-1:0]         flush;
    logic [STAGES-1:0]         stage_valid;
    logic [STAGES*WIDTH-1:0]   stage_data;
    logic                      out_fire;

    modport master (
        output in_valid, in_data, hold, flush,
        input  in_ready, stage_valid, stage_data, out_fire
    );

    modport slave (
        input  in_valid, in_data, hold, flush,
        output in_ready, stage_valid, stage_data, out_fire
    );
endinterface

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline register slot: flush beats freeze, freeze beats bubble/load
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             freeze,
    input  logic             flush,
    input  logic             bubble_sel,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q_valid <= 1'b0;
            q_data  <= {WIDTH{PIPE_BUBBLE_BIT}};
        end else if (flush) begin
            q_valid <= 1'b0;
            q_data  <= {WIDTH{PIPE_BUBBLE_BIT}};
        end else if (!freeze) begin
            if (bubble_sel) begin
                q_valid <= 1'b0;
                q_data  <= {WIDTH{PIPE_BUBBLE_BIT}};
            end else begin
                q_valid <= prev_valid;
                q_data  <= prev_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - STAGES-deep pipeline register chain with hold/flush/bubble control
// and saturating stall/bubble/flush performance counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int WIDTH  = 128,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    pipe_stage_chain_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [STAGES-1:0]       freeze;
    logic [STAGES-1:0]       bub_sel;
    logic [STAGES-1:0]       v_q;
    logic [STAGES*WIDTH-1:0] d_q;
    logic                    stall_ev;
    logic                    bubble_ev;
    logic                    flush_ev;

    // A slot is frozen when it or any older slot is held.
    always_comb begin
        freeze  = '0;
        bub_sel = '0;
        for (int s = 0; s < STAGES; s++) begin
            freeze[s] = |(bus.hold >> s);
        end
        for (int s = 1; s < STAGES; s++) begin
            bub_sel[s] = freeze[s-1] & ~freeze[s];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_slot
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;

        if (s == 0) begin : g_head
            assign prev_valid = bus.in_valid;
            assign prev_data  = bus.in_data;
        end else begin : g_body
            assign prev_valid = v_q[s-1];
            assign prev_data  = d_q[(s-1)*WIDTH +: WIDTH];
        end

        pipe_slot #(.WIDTH(WIDTH)) u_slot (
            .CLK        (CLK),
            .nRST       (nRST),
            .freeze     (freeze[s]),
            .flush      (bus.flush[s]),
            .bubble_sel (bub_sel[s]),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .q_valid    (v_q[s]),
            .q_data     (d_q[s*WIDTH +: WIDTH])
        );
    end

    assign bus.in_ready    = ~freeze[0];
    assign bus.out_fire    = v_q[STAGES-1] & ~freeze[STAGES-1] & ~bus.flush[STAGES-1];
    assign bus.stage_valid = v_q;
    assign bus.stage_data  = d_q;

    assign stall_ev  = bus.in_valid & freeze[0];
    assign bubble_ev = |(bub_sel & ~bus.flush);
    assign flush_ev  = |(bus.flush & v_q);

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic ev);
        return (ev && (c != '1)) ? c + {{(CNT_W-1){1'b0}}, 1'b1} : c;
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            stall_cnt  <= bump(stall_cnt, stall_ev);
            bubble_cnt <= bump(bubble_cnt, bubble_ev);
            flush_cnt  <= bump(flush_cnt, flush_ev);
        end
    end

endmodule
